// File: rtl/imm_pkg.sv
// Shared types for the immediate-generator slice: immediate format selector and
// skid-buffer occupancy states.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational I/S/B/U/J immediate reconstruction from instr[31:7], sign-extended
// from instr[31] to DATAWIDTH; reserved selectors yield zero and flag illegal_o.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic [31:0]          instr_i,
    input  logic [2:0]           imm_src_i,
    output logic [DATAWIDTH-1:0] imm_o,
    output logic                 illegal_o
);

    logic [31:0] imm32;
    logic        unused_opcode;

    // Opcode field carries no immediate bits.
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        case (imm_src_e'(imm_src_i))
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = DATAWIDTH'($signed(imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator behind a valid/ready handshake with a 2-entry skid buffer.
// Optional IMM_ILLEGAL_CHK_EN adds the registered illegal_o flag for reserved selectors.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TAG_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [2:0]           imm_src_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATAWIDTH-1:0] imm_o,
    output logic [TAG_W-1:0]     tag_o
`ifdef IMM_ILLEGAL_CHK_EN
    ,
    output logic                 illegal_o
`endif
);

    skid_state_e          state_q, state_d;
    logic [DATAWIDTH-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0]     main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic [DATAWIDTH-1:0] dec_imm;
    logic                 dec_ill;
    logic                 accept, drain;
`ifdef IMM_ILLEGAL_CHK_EN
    logic                 main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
`else
    logic                 unused_dec_ill;
    assign unused_dec_ill = dec_ill;
`endif

    imm_extend_core #(
        .DATAWIDTH(DATAWIDTH)
    ) u_core (
        .instr_i  (instr_i),
        .imm_src_i(imm_src_i),
        .imm_o    (dec_imm),
        .illegal_o(dec_ill)
    );

    assign ready_o = (state_q != FULL);
    assign valid_o = (state_q != EMPTY);
    assign accept  = valid_i && ready_o;
    assign drain   = valid_o && ready_i;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
`ifdef IMM_ILLEGAL_CHK_EN
        main_ill_d = main_ill_q;
        skid_ill_d = skid_ill_q;
`endif
        if (flush_i) begin
            state_d    = EMPTY;
            main_imm_d = '0;
            main_tag_d = '0;
            skid_imm_d = '0;
            skid_tag_d = '0;
`ifdef IMM_ILLEGAL_CHK_EN
            main_ill_d = 1'b0;
            skid_ill_d = 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d    = ONE;
                    main_imm_d = dec_imm;
                    main_tag_d = tag_i;
`ifdef IMM_ILLEGAL_CHK_EN
                    main_ill_d = dec_ill;
`endif
                end
                ONE: begin
                    // Simultaneous accept and drain reloads main; lone accept parks in skid.
                    if (accept && drain) begin
                        main_imm_d = dec_imm;
                        main_tag_d = tag_i;
`ifdef IMM_ILLEGAL_CHK_EN
                        main_ill_d = dec_ill;
`endif
                    end else if (accept) begin
                        state_d    = FULL;
                        skid_imm_d = dec_imm;
                        skid_tag_d = tag_i;
`ifdef IMM_ILLEGAL_CHK_EN
                        skid_ill_d = dec_ill;
`endif
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    state_d    = ONE;
                    main_imm_d = skid_imm_q;
                    main_tag_d = skid_tag_q;
`ifdef IMM_ILLEGAL_CHK_EN
                    main_ill_d = skid_ill_q;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
`ifdef IMM_ILLEGAL_CHK_EN
            main_ill_q <= 1'b0;
            skid_ill_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
`ifdef IMM_ILLEGAL_CHK_EN
            main_ill_q <= main_ill_d;
            skid_ill_q <= skid_ill_d;
`endif
        end
    end

    assign imm_o = main_imm_q;
    assign tag_o = main_tag_q;
`ifdef IMM_ILLEGAL_CHK_EN
    assign illegal_o = main_ill_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe at DATAWIDTH 32 and 64 sharing one input stream; honours
// IMM_ILLEGAL_CHK_EN when defined.
module tb_imm_extend_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n_i, flush_i, valid_i, ready_i;
    logic [31:0] instr_i, tag_i;
    logic [2:0]  imm_src_i;
    logic        ready32, ready64, valid32, valid64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
`ifdef IMM_ILLEGAL_CHK_EN
    logic        ill32, ill64;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATAWIDTH(32), .TAG_W(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready32), .instr_i(instr_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
        .valid_o(valid32), .ready_i(ready_i), .imm_o(imm32), .tag_o(tag32)
`ifdef IMM_ILLEGAL_CHK_EN
        , .illegal_o(ill32)
`endif
    );

    imm_extend_pipe #(.DATAWIDTH(64), .TAG_W(32)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready64), .instr_i(instr_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
        .valid_o(valid64), .ready_i(ready_i), .imm_o(imm64), .tag_o(tag64)
`ifdef IMM_ILLEGAL_CHK_EN
        , .illegal_o(ill64)
`endif
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference immediates via signed shifts and masks on a 64-bit value.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
        longint s;
        longint r;
        s = longint'($signed(ins));
        case (src)
            3'd0: r = s >>> 20;
            3'd1: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) <<< 11)
                      | (longint'(ins[30:25]) <<< 5) | (longint'(ins[11:8]) <<< 1);
            3'd3: r = (s >>> 12) <<< 12;
            3'd4: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) <<< 12)
                      | (longint'(ins[20]) <<< 11) | (longint'(ins[30:21]) <<< 1);
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        chk("valid32", {63'd0, valid32}, {63'd0, q.size() != 0});
        chk("valid64", {63'd0, valid64}, {63'd0, q.size() != 0});
        chk("ready32", {63'd0, ready32}, {63'd0, q.size() < 2});
        chk("ready64", {63'd0, ready64}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            chk("imm32", {32'd0, imm32}, {32'd0, q[0].imm[31:0]});
            chk("imm64", imm64, q[0].imm);
            chk("tag32", {32'd0, tag32}, {32'd0, q[0].tag});
            chk("tag64", {32'd0, tag64}, {32'd0, q[0].tag});
`ifdef IMM_ILLEGAL_CHK_EN
            chk("ill32", {63'd0, ill32}, {63'd0, q[0].ill});
            chk("ill64", {63'd0, ill64}, {63'd0, q[0].ill});
`endif
        end
    endtask

    // One clock: check current outputs, drive inputs for the next edge, advance the model.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] ins,
                         input logic [31:0] tg, input logic r, input logic f);
        bit   rdy_m;
        ent_t e;
        @(negedge clk);
        check_outputs();
        valid_i   = v;
        imm_src_i = s;
        instr_i   = ins;
        tag_i     = tg;
        ready_i   = r;
        flush_i   = f;
        if (f) begin
            q.delete();
        end else begin
            rdy_m = (q.size() < 2);
            if (q.size() != 0 && r) void'(q.pop_front());
            if (v && rdy_m) begin
                e.imm = ref_imm(ins, s);
                e.tag = tg;
                e.ill = (s > 3'd4);
                q.push_back(e);
            end
        end
    endtask

    initial begin
        tbl[0] = '{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1] = '{32'hFE20AE23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[2] = '{32'hFE000CE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8};
        tbl[3] = '{32'h123450B7, 3'd3, 64'h0000_0000_1234_5000};
        tbl[4] = '{32'hFFDFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[5] = '{32'hFFFFFFFF, 3'd6, 64'h0};
        tbl[6] = '{32'h7FF00013, 3'd0, 64'h0000_0000_0000_07FF};
        tbl[7] = '{32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000};

        rst_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr_i = '0; imm_src_i = '0; tag_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {62'd0, valid32, valid64}, 64'd0);
        chk("rst_ready", {62'd0, ready32, ready64}, 64'd3);
        chk("rst_imm", imm64 | {32'd0, imm32}, 64'd0);
        chk("rst_tag", {tag64, tag32}, 64'd0);
        rst_n_i = 1'b1;

        for (int unsigned i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].src, tbl[i].instr, 32'hA000 + i, 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("tbl_imm64", imm64, tbl[i].exp);
            chk("tbl_imm32", {32'd0, imm32}, {32'd0, tbl[i].exp[31:0]});
`ifdef IMM_ILLEGAL_CHK_EN
            chk("tbl_ill", {63'd0, ill64}, {63'd0, tbl[i].src > 3'd4});
`endif
            cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Backpressure: three entries, downstream stalled, then released.
        cycle(1'b1, 3'd0, 32'h00100013, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 32'h0020A423, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 32'hABCDE037, 32'h33, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("bp_ready_full", {62'd0, ready32, ready64}, 64'd0);
        cycle(1'b1, 3'd3, 32'hABCDE037, 32'h33, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 32'hABCDE037, 32'h33, 1'b1, 1'b0);
        cycle(1'b1, 3'd3, 32'hABCDE037, 32'h33, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with a valid input present.
        cycle(1'b1, 3'd0, 32'h12300013, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 32'h45600013, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 32'h78900013, 32'h66, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("flush_valid", {62'd0, valid32, valid64}, 64'd0);
        chk("flush_ready", {62'd0, ready32, ready64}, 64'd3);
        repeat (2) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        cycle(1'b1, 3'd4, 32'h0040006F, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 32'h00208463, 32'h88, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_valid", {62'd0, valid32, valid64}, 64'd0);
        chk("arst_ready", {62'd0, ready32, ready64}, 64'd3);
        chk("arst_imm", imm64 | {32'd0, imm32}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n_i = 1'b1;

        for (int unsigned n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        repeat (3) cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
